smc777_mem_arbiter: RTL and testbench

Single-port main/video RAM arbiter for the SMC-777 core. It shares one synchronous 64 KiB × 8 RAM between three requesters: the CRTC character/attribute fetch, the Z80 CPU bus, and the HPS ioctl download path. The video fetch gets fixed-latency access. The CPU and the download path are stalled through wait handshakes.

---
 rtl/smc777_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_smc777_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smc777_mem_arbiter.sv
// Single-port RAM arbiter for the SMC-777 core: CRTC fetch > ioctl download > Z80 bus.
// The ioctl download path is compiled in only when SMC777_IOCTL_LOAD_EN is defined.
module smc777_mem_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          vid_req_i,
  input  logic [AW-1:0] vid_addr_i,
  output logic          vid_valid_o,
  output logic [DW-1:0] vid_data_o,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_din_i,
  output logic [DW-1:0] cpu_dout_o,
  output logic          cpu_ack_o,
  output logic          cpu_wait_o,
  input  logic          ioctl_download_i,
  input  logic          ioctl_wr_i,
  input  logic [24:0]   ioctl_addr_i,
  input  logic [7:0]    ioctl_dout_i,
  output logic          ioctl_wait_o,
  output logic [AW-1:0] ram_addr_o,
  output logic          ram_we_o,
  output logic [DW-1:0] ram_din_o,
  input  logic [DW-1:0] ram_dout_i
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_IOC  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_e;

  owner_e        iss_q, iss_d, ret_q;
  logic          ret_we_q;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          vid_valid_q;
  logic [DW-1:0] vid_data_q;
  logic          cpu_ack_q;
  logic [DW-1:0] cpu_dout_q;
  logic          cpu_busy;
  logic          hold_full_q;
  logic [AW-1:0] hold_addr_q;
  logic [DW-1:0] hold_data_q;

`ifdef SMC777_IOCTL_LOAD_EN
  logic          hold_full_d;
  logic [AW-1:0] hold_addr_d;
  logic [DW-1:0] hold_data_d;
  logic          ioc_capture;

  // Bytes outside the 64 KiB window are dropped; strobes while full are ignored
  assign ioc_capture = ioctl_wr_i & ioctl_download_i & ~hold_full_q &
                       (ioctl_addr_i[24:16] == 9'd0);

  always_comb begin
    hold_full_d = hold_full_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    if (hold_full_q && !vid_req_i) begin
      hold_full_d = 1'b0;
    end
    if (ioc_capture) begin
      hold_full_d = 1'b1;
      hold_addr_d = AW'(ioctl_addr_i[15:0]);
      hold_data_d = DW'(ioctl_dout_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      hold_full_q <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign ioctl_wait_o = hold_full_q;
`else
  logic unused_ioctl;

  assign hold_full_q  = 1'b0;
  assign hold_addr_q  = '0;
  assign hold_data_q  = '0;
  assign ioctl_wait_o = 1'b0;
  assign unused_ioctl = ^{ioctl_download_i, ioctl_wr_i, ioctl_addr_i, ioctl_dout_i};
`endif

  // A CPU access stays in flight until the cycle its ack is visible
  assign cpu_busy = (iss_q == OWN_CPU) | (ret_q == OWN_CPU) | cpu_ack_q;

  always_comb begin
    iss_d      = OWN_NONE;
    ram_addr_d = ram_addr_q;
    ram_we_d   = 1'b0;
    ram_din_d  = ram_din_q;
    if (vid_req_i) begin
      iss_d      = OWN_VID;
      ram_addr_d = vid_addr_i;
    end else if (hold_full_q) begin
      iss_d      = OWN_IOC;
      ram_addr_d = hold_addr_q;
      ram_we_d   = 1'b1;
      ram_din_d  = hold_data_q;
    end else if (cpu_req_i && !cpu_busy) begin
      iss_d      = OWN_CPU;
      ram_addr_d = cpu_addr_i;
      ram_we_d   = cpu_we_i;
      if (cpu_we_i) begin
        ram_din_d = cpu_din_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      iss_q       <= OWN_NONE;
      ret_q       <= OWN_NONE;
      ret_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_dout_q  <= '0;
    end else begin
      iss_q       <= iss_d;
      ret_q       <= iss_q;
      ret_we_q    <= ram_we_q;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
      vid_valid_q <= (ret_q == OWN_VID);
      cpu_ack_q   <= (ret_q == OWN_CPU);
      if (ret_q == OWN_VID) begin
        vid_data_q <= ram_dout_i;
      end
      if ((ret_q == OWN_CPU) && !ret_we_q) begin
        cpu_dout_q <= ram_dout_i;
      end
    end
  end

  assign vid_valid_o = vid_valid_q;
  assign vid_data_o  = vid_data_q;
  assign cpu_ack_o   = cpu_ack_q;
  assign cpu_dout_o  = cpu_dout_q;
  assign cpu_wait_o  = cpu_req_i & ~cpu_ack_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_we_o    = ram_we_q;
  assign ram_din_o   = ram_din_q;

endmodule

// File: tb/tb_smc777_mem_arbiter.sv
// Bench for smc777_mem_arbiter: slot-schedule model of the arbitration rules plus directed checks.
// Works with and without SMC777_IOCTL_LOAD_EN.
module tb_smc777_mem_arbiter;

`ifdef SMC777_IOCTL_LOAD_EN
  localparam bit IOC_EN = 1'b1;
`else
  localparam bit IOC_EN = 1'b0;
`endif
  localparam int MAXC = 40000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vid_req = 1'b0;
  logic [15:0] vid_addr = '0;
  logic        vid_valid;
  logic [7:0]  vid_data;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        cpu_wait;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  smc777_mem_arbiter #(.AW(16), .DW(8)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_valid_o(vid_valid), .vid_data_o(vid_data),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_din_i(cpu_din),
    .cpu_dout_o(cpu_dout), .cpu_ack_o(cpu_ack), .cpu_wait_o(cpu_wait),
    .ioctl_download_i(ioctl_download), .ioctl_wr_i(ioctl_wr), .ioctl_addr_i(ioctl_addr),
    .ioctl_dout_i(ioctl_dout), .ioctl_wait_o(ioctl_wait),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
  );

  always #5 clk = ~clk;

  // External synchronous RAM, read-first
  logic [7:0] ram_mem [0:65535];
  always @(posedge clk) begin
    ram_dout <= ram_mem[ram_addr];
    if (ram_we) ram_mem[ram_addr] = ram_din;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit stop_bg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_expired(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got no event within bound, want event (cycle %0d)", name, cyc);
  endtask

  // Model: each edge grants one slot (video > held ioctl byte > CPU); results land two edges later
  logic [7:0]  shadow [0:65535];
  bit          exp_vv [MAXC];
  logic [7:0]  exp_vd [MAXC];
  bit          exp_ack[MAXC];
  bit          exp_rd [MAXC];
  logic [7:0]  exp_do [MAXC];
  bit          m_full, m_cap, m_vv, m_ack, m_we, m_wait;
  logic [15:0] m_haddr, m_addr;
  logic [7:0]  m_hdata, m_vd, m_dout, m_din;
  int          m_cpu_until = -1;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 8'(i * 7 + 3);
      shadow[i]  = 8'(i * 7 + 3);
    end
    ram_mem[16'h1234] = 8'h5A;
    shadow[16'h1234]  = 8'h5A;
  end

  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      for (int d = 0; d < 3; d++) begin
        exp_vv[cyc + d] = 1'b0; exp_ack[cyc + d] = 1'b0; exp_rd[cyc + d] = 1'b0;
      end
      m_full = 1'b0; m_cpu_until = -1;
      m_vv = 1'b0; m_vd = '0; m_ack = 1'b0; m_dout = '0;
      m_we = 1'b0; m_addr = '0; m_din = '0;
    end else begin
      m_cap = IOC_EN && ioctl_wr && ioctl_download && !m_full && (ioctl_addr[24:16] == 9'd0);
      m_we = 1'b0;
      if (vid_req) begin
        exp_vv[cyc + 2] = 1'b1;
        exp_vd[cyc + 2] = shadow[vid_addr];
        m_addr = vid_addr;
      end else if (m_full) begin
        shadow[m_haddr] = m_hdata;
        m_full = 1'b0;
        m_we = 1'b1; m_addr = m_haddr; m_din = m_hdata;
      end else if (cpu_req && cyc > m_cpu_until) begin
        m_addr = cpu_addr;
        m_cpu_until = cyc + 3;
        exp_ack[cyc + 2] = 1'b1;
        if (cpu_we) begin
          shadow[cpu_addr] = cpu_din;
          m_we = 1'b1; m_din = cpu_din;
        end else begin
          exp_rd[cyc + 2] = 1'b1;
          exp_do[cyc + 2] = shadow[cpu_addr];
        end
      end
      if (m_cap) begin
        m_full = 1'b1; m_haddr = ioctl_addr[15:0]; m_hdata = ioctl_dout;
      end
      m_vv = exp_vv[cyc];
      if (m_vv) m_vd = exp_vd[cyc];
      m_ack = exp_ack[cyc];
      if (exp_rd[cyc]) m_dout = exp_do[cyc];
    end
    m_wait = m_full;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("vid_valid", vid_valid, m_vv);
      check("vid_data", vid_data, m_vd);
      check("cpu_ack", cpu_ack, m_ack);
      check("cpu_dout", cpu_dout, m_dout);
      check("cpu_wait", cpu_wait, cpu_req & ~m_ack);
      check("ioctl_wait", ioctl_wait, m_wait);
      check("ram_we", ram_we, m_we);
      check("ram_addr", ram_addr, m_addr);
      if (m_we) check("ram_din", ram_din, m_din);
    end
  end

  task automatic cpu_access(input bit we, input logic [15:0] a, input logic [7:0] d,
                            output int lat, output logic [7:0] rd);
    int t0;
    @(posedge clk); #2;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    t0 = cyc + 1;
    lat = -1; rd = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        lat = cyc - t0; rd = cpu_dout;
        break;
      end
    end
    if (lat < 0) bound_expired("cpu_ack_timeout");
    @(posedge clk); #2;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic vid_fetch(input logic [15:0] a, output int lat, output logic [7:0] rd);
    int t0;
    @(posedge clk); #2;
    vid_req = 1'b1; vid_addr = a;
    t0 = cyc + 1;
    @(posedge clk); #2;
    vid_req = 1'b0;
    lat = -1; rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vid_valid) begin
        lat = cyc - t0; rd = vid_data;
        break;
      end
    end
    if (lat < 0) bound_expired("vid_valid_timeout");
  endtask

  task automatic vid_pulser(input int gap);
    while (!stop_bg) begin
      @(posedge clk); #2;
      vid_req = 1'b1; vid_addr = 16'($urandom);
      @(posedge clk); #2;
      vid_req = 1'b0;
      repeat (gap - 2) @(posedge clk);
    end
  endtask

  task automatic ioc_strobe(input logic [24:0] a, input logic [7:0] d, input bit dl_after);
    int n = 0;
    while (ioctl_wait === 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    if (n >= 20) bound_expired("ioctl_wait_stuck");
    @(posedge clk); #2;
    ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(posedge clk); #2;
    ioctl_wr = 1'b0; ioctl_download = dl_after;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    bound_expired("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int lat, lat2;
    logic [7:0] rd, rd2;

    // Reset with random traffic
    repeat (3) begin
      @(posedge clk); #2;
      vid_req = 1'($urandom); vid_addr = 16'($urandom);
      cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = 16'($urandom);
      ioctl_wr = 1'($urandom); ioctl_download = 1'($urandom); ioctl_addr = 25'($urandom & 32'hFFFF);
    end
    @(negedge clk);
    check("rst_vid_valid", vid_valid, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_cpu_dout", cpu_dout, 0);
    check("rst_ioctl_wait", ioctl_wait, 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; ioctl_wr = 1'b0; ioctl_download = 1'b0;

    // CPU write then read back
    cpu_access(1'b1, 16'h8000, 8'hA5, lat, rd);
    check("cpu_wr_latency", 32'(lat), 2);
    cpu_access(1'b0, 16'h8000, 8'h00, lat, rd);
    check("cpu_rd_latency", 32'(lat), 2);
    check("cpu_rd_data", rd, 8'hA5);

    // Video and CPU requested together: video keeps latency 2, CPU slips one slot
    fork
      vid_fetch(16'h1234, lat, rd);
      cpu_access(1'b0, 16'h8000, 8'h00, lat2, rd2);
    join
    check("vid_latency", 32'(lat), 2);
    check("vid_data_1234", rd, 8'h5A);
    check("cpu_latency_vs_vid", 32'(lat2), 3);
    check("cpu_rd_data_vs_vid", rd2, 8'hA5);

    // Contention: video every 2 cycles against a CPU read stream
    stop_bg = 1'b0;
    fork
      vid_pulser(2);
      begin
        for (int i = 0; i < 16; i++) begin
          cpu_access(1'b0, 16'h9000 + 16'(i), 8'h00, lat, rd);
          check($sformatf("cpu_lat_contention lat=%0d", lat), 32'(lat >= 2 && lat <= 3), 1);
        end
        stop_bg = 1'b1;
      end
    join

    // Download 256 bytes under video and CPU traffic, then one out-of-range byte
    stop_bg = 1'b0;
    fork
      vid_pulser(3);
      while (!stop_bg) cpu_access(1'b0, 16'h8000, 8'h00, lat, rd);
      begin
        for (int i = 0; i < 256; i++) ioc_strobe(25'(i), 8'(i) ^ 8'h3C, i != 255);
        ioc_strobe(25'h010000, 8'hEE, 1'b0);
        check("ioctl_wait_drop0", ioctl_wait, 0);
        @(negedge clk);
        check("ioctl_wait_drop1", ioctl_wait, 0);
        @(negedge clk);
        check("ioctl_wait_drop2", ioctl_wait, 0);
        stop_bg = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 256; i++) check($sformatf("ram_mem[%0d]", i), ram_mem[i], shadow[i]);
`ifdef SMC777_IOCTL_LOAD_EN
    check("dl_byte_0000", ram_mem[0], 8'h3C);
    check("dl_byte_00FF", ram_mem[255], 8'hC3);
`else
    check("no_dl_byte_0000", ram_mem[0], 8'h03);
    check("no_dl_byte_00FF", ram_mem[255], 8'hFC);
`endif

    // Reset on the issue cycle of a CPU read
    @(posedge clk); #2;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8000;
    @(posedge clk); #2;
    reset_n = 1'b0; cpu_req = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_cpu_ack", cpu_ack, 0);
      check("post_rst_cpu_dout", cpu_dout, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
